control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle sequencer for the 16-bit simple processor: latches an instruction word from the data-in bus, then drives, cycle by cycle, the one-hot load enables of the `register_bank` instances, the bus-driver selects, and the ALU operation. It sits directly upstream of the register bank and supplies the `enable` each register consumes. It also supplies the A/G accumulator-path enables and signals instruction completion with `done`.

## Interface

Parameters:
- `DATA_WIDTH`, 16: width of `din` and the instruction register.
- `NUM_REGS`, 8: number of general registers; register index fields are log2(NUM_REGS) = 3 bits.

Ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `run`  in  1: start request, sampled only in state T0.
- `din`  in  DATA_WIDTH: instruction / immediate input.
- `r_in`  out  NUM_REGS: one-hot load enables, one per `register_bank`.
- `r_out`  out  NUM_REGS: one-hot bus-drive selects, one per register.
- `a_in`  out  1: load enable for ALU operand register A.
- `g_in`  out  1: load enable for ALU result register G.
- `g_out`  out  1: G drives the bus.
- `din_out`  out  1: `din` drives the bus.
- `alu_sub`  out  1: 0 = add, 1 = subtract; meaningful only while `g_in` = 1.
- `done`  out  1: one-cycle pulse in the final cycle of each instruction.

## Operation

- Instruction format:
  - `IR[15:12]` opcode.
  - `IR[11:9]` rx (destination / first operand).
  - `IR[8:6]` ry (source / second operand).
  - `IR[5:0]` ignored.
- Opcodes: MV = 0 (rx ← ry), MVI = 1 (rx ← next `din`), ADD = 2 (rx ← rx + ry), SUB = 3 (rx ← rx − ry). Opcodes 4–15 are NOP.
- FSM states are T0, T1, T2 and T3. Outputs are decoded combinationally from the state and IR; every output not listed for a state is 0.
- T0:
  - If `run` = 1: `ir_in` is asserted internally, IR ← `din` at the clock edge, next state T1.
  - If `run` = 0: stay in T0, no outputs asserted.
- T1:
  - MV: `r_out[ry]`, `r_in[rx]`, `done`; next state T0.
  - MVI: `din_out`, `r_in[rx]`, `done`; next state T0.
  - ADD/SUB: `r_out[rx]`, `a_in`; next state T2.
  - NOP: `done` only; next state T0.
- T2 (ADD/SUB only): `r_out[ry]`, `g_in`, `alu_sub` = (opcode == SUB); next state T3.
- T3: `g_out`, `r_in[rx]`, `done`; next state T0.
- Bus exclusivity invariant: at most one of `r_out[*]`, `g_out`, `din_out` is 1 in any cycle.
- `r_in` is zero or one-hot. It is never multi-hot.
- MV with rx == ry is legal. It asserts `r_out[k]` and `r_in[k]` together, which is a harmless self-reload.

## Timing

- Reset (`reset_n` = 0, asynchronous): state ← T0 and IR ← 0 immediately. All outputs are 0 while reset is held and in the first cycle after release, unless `run` is already 1 in that cycle.
- Reset mid-instruction: the instruction is abandoned, no `r_in` is asserted, and `done` is not pulsed.
- Latency counted from the edge at which T0 samples `run` = 1:
  - MV, MVI, NOP: `done` in the next cycle, so 2 cycles total.
  - ADD, SUB: `done` in the 3rd cycle after, so 4 cycles total.
- Register write timing: the destination register captures the bus at the same rising edge that ends the `done` cycle.
- `run` is ignored in T1–T3; holding it high does not restart the instruction.
- Back-to-back: if `run` = 1 in the T0 following `done`, the next instruction is fetched with no idle cycle.
- MVI immediate: the immediate must be on `din` during T1. `din` during T0 is the instruction word.
- `alu_sub` is 0 in every state except T2.

## Structure

- Shared package `proc_defs`:
  - opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`;
  - state encoding `T0`–`T3` (2-bit);
  - field bit positions for opcode, rx and ry.
  - The future datapath and ALU blocks include the same package.
- Sub-module `reg_decoder`: 3-to-8 one-hot decoder with an enable input. It is instantiated twice, once for `r_in` and once for `r_out`.
- Top level holds the IR, the state register, the next-state logic and the output decode.

## Test plan

- Reset: assert `reset_n` = 0 mid-T2 of an ADD → all outputs 0 at once, FSM in T0; after release with `run` = 0, no output toggles for 5 cycles.
- MV: `din` = 0x0200 (MV R1, R0), `run` pulse → T1 shows `r_out` = 0x01, `r_in` = 0x02, `done` = 1; the next cycle is T0.
- MVI: `din` = 0x1A00 (MVI R5), then `din` = 45 in T1 → T1 shows `din_out` = 1, `r_in` = 0x20, `done` = 1, and R5 holds 45 after the edge.
- ADD: `din` = 0x2480 (ADD R2, R2 ← R2 + R2) →
  - T1: `r_out` = 0x04, `a_in` = 1;
  - T2: `r_out` = 0x04, `g_in` = 1, `alu_sub` = 0;
  - T3: `g_out` = 1, `r_in` = 0x04, `done` = 1.
- SUB then back-to-back: `din` = 0x3640 (SUB R3, R1) followed immediately by MV →
  - SUB: `alu_sub` = 1 only in T2, `done` in cycle 4;
  - MV: T1 occurs 2 cycles after the SUB `done`.
- NOP and invariants: `din` = 0xF000 → `done` in T1 with `r_in` = 0.
  - A continuous bench assertion checks bus-driver exclusivity and that `r_in` is zero or one-hot.

Source files
------------

// File: rtl/proc_defs.sv
// Shared definitions for the 16-bit simple processor:
// opcodes, sequencer states and instruction field positions.
package proc_defs;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [3:0] OP_MV  = 4'd0;
    localparam logic [3:0] OP_MVI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;

    localparam int OP_LO = 12;
    localparam int OP_W  = 4;
    localparam int RX_LO = 9;
    localparam int RY_LO = 6;

endpackage

// File: rtl/reg_decoder.sv
// Index-to-one-hot decoder with enable; all zeros when disabled.
// Used for both the register load enables and the bus-drive selects.
module reg_decoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         en,
    input  logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetches an instruction word from din and
// steps T0..T3 driving register, bus and ALU controls.
module control_unit
    import proc_defs::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [NUM_REGS-1:0]   r_in,
    output logic [NUM_REGS-1:0]   r_out,
    output logic                  a_in,
    output logic                  g_in,
    output logic                  g_out,
    output logic                  din_out,
    output logic                  alu_sub,
    output logic                  done
);

    localparam int IW = $clog2(NUM_REGS);

    state_t                state;
    state_t                nxt;
    logic [DATA_WIDTH-1:0] ir;
    logic                  ir_in;

    logic [OP_W-1:0] opcode;
    logic [IW-1:0]   rx;
    logic [IW-1:0]   ry;
    logic            is_mv;
    logic            is_mvi;
    logic            is_alu;
    logic            is_sub;

    logic            rin_en;
    logic            rout_en;
    logic [IW-1:0]   rout_idx;
    logic            unused_ir;

    assign opcode = ir[OP_LO +: OP_W];
    assign rx     = ir[RX_LO +: IW];
    assign ry     = ir[RY_LO +: IW];
    assign is_mv  = (opcode == OP_MV);
    assign is_mvi = (opcode == OP_MVI);
    assign is_sub = (opcode == OP_SUB);
    assign is_alu = (opcode == OP_ADD) || is_sub;

    assign unused_ir = ^ir[RY_LO-1:0];

    always_comb begin
        nxt      = state;
        ir_in    = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_idx = rx;
        a_in     = 1'b0;
        g_in     = 1'b0;
        g_out    = 1'b0;
        din_out  = 1'b0;
        alu_sub  = 1'b0;
        done     = 1'b0;
        unique case (state)
            T0: begin
                if (run) begin
                    ir_in = 1'b1;
                    nxt   = T1;
                end
            end
            T1: begin
                unique case (1'b1)
                    is_mv: begin
                        rout_en  = 1'b1;
                        rout_idx = ry;
                        rin_en   = 1'b1;
                        done     = 1'b1;
                        nxt      = T0;
                    end
                    is_mvi: begin
                        din_out = 1'b1;
                        rin_en  = 1'b1;
                        done    = 1'b1;
                        nxt     = T0;
                    end
                    is_alu: begin
                        rout_en = 1'b1;
                        a_in    = 1'b1;
                        nxt     = T2;
                    end
                    default: begin
                        done = 1'b1;
                        nxt  = T0;
                    end
                endcase
            end
            T2: begin
                rout_en  = 1'b1;
                rout_idx = ry;
                g_in     = 1'b1;
                alu_sub  = is_sub;
                nxt      = T3;
            end
            T3: begin
                g_out  = 1'b1;
                rin_en = 1'b1;
                done   = 1'b1;
                nxt    = T0;
            end
            default: nxt = T0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= nxt;
            if (ir_in) begin
                ir <= din;
            end
        end
    end

    reg_decoder #(.N(NUM_REGS), .W(IW)) u_rin_dec (
        .en     (rin_en),
        .idx    (rx),
        .onehot (r_in)
    );

    reg_decoder #(.N(NUM_REGS), .W(IW)) u_rout_dec (
        .en     (rout_en),
        .idx    (rout_idx),
        .onehot (r_out)
    );

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a small behavioural
// register bank / accumulator datapath driven by its controls.
module tb_control_unit;

    logic        clock;
    logic        reset_n;
    logic        run;
    logic [15:0] din;
    logic [7:0]  r_in;
    logic [7:0]  r_out;
    logic        a_in;
    logic        g_in;
    logic        g_out;
    logic        din_out;
    logic        alu_sub;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [15:0] regs [8] = '{16'h1111, 16'h2222, 16'h0003, 16'h0010,
                              16'h0044, 16'h0000, 16'h0066, 16'h0077};
    logic [15:0] acc_a = '0;
    logic [15:0] acc_g = '0;
    logic [15:0] bus;

    control_unit #(.DATA_WIDTH(16), .NUM_REGS(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (run),
        .din     (din),
        .r_in    (r_in),
        .r_out   (r_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .g_out   (g_out),
        .din_out (din_out),
        .alu_sub (alu_sub),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        bus = '0;
        if (din_out) bus = din;
        else if (g_out) bus = acc_g;
        else begin
            for (int i = 0; i < 8; i++) begin
                if (r_out[i]) bus = regs[i];
            end
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 8; i++) begin
            if (r_in[i]) regs[i] <= bus;
        end
        if (a_in) acc_a <= bus;
        if (g_in) acc_g <= alu_sub ? (acc_a - bus) : (acc_a + bus);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags = {a_in, g_in, g_out, din_out, alu_sub, done}
    task automatic cout(input string tag, input logic [7:0] rin,
                        input logic [7:0] rout, input logic [5:0] flags);
        chk(tag, {10'd0, r_in, r_out, a_in, g_in, g_out,
                  din_out, alu_sub, done},
            {10'd0, rin, rout, flags});
    endtask

    task automatic tick(input logic r, input logic [15:0] d);
        @(negedge clock);
        run = r;
        din = d;
        #1;
        chk("bus_excl", {31'd0, $onehot0({r_out, g_out, din_out})}, 32'd1);
        chk("rin_onehot0", {31'd0, $onehot0(r_in)}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        din     = '0;
        #1;
        cout("reset_outs", 8'h00, 8'h00, 6'b000000);
        chk("reset_ir", {16'd0, dut.ir}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        cout("post_release", 8'h00, 8'h00, 6'b000000);

        // MV R1, R0
        tick(1'b1, 16'h0200);
        cout("mv_t0", 8'h00, 8'h00, 6'b000000);
        tick(1'b0, 16'h0000);
        cout("mv_t1", 8'h02, 8'h01, 6'b000001);
        tick(1'b0, 16'h0000);
        cout("mv_back_t0", 8'h00, 8'h00, 6'b000000);
        chk("mv_r1", {16'd0, regs[1]}, 32'h1111);

        // MVI R5, 45
        tick(1'b1, 16'h1A00);
        cout("mvi_t0", 8'h00, 8'h00, 6'b000000);
        tick(1'b0, 16'd45);
        cout("mvi_t1", 8'h20, 8'h00, 6'b000101);
        tick(1'b0, 16'h0000);
        cout("mvi_back_t0", 8'h00, 8'h00, 6'b000000);
        chk("mvi_r5", {16'd0, regs[5]}, 32'd45);

        // ADD R2, R2
        tick(1'b1, 16'h2480);
        cout("add_t0", 8'h00, 8'h00, 6'b000000);
        tick(1'b0, 16'h0000);
        cout("add_t1", 8'h00, 8'h04, 6'b100000);
        tick(1'b0, 16'h0000);
        cout("add_t2", 8'h00, 8'h04, 6'b010000);
        tick(1'b0, 16'h0000);
        cout("add_t3", 8'h04, 8'h00, 6'b001001);
        tick(1'b0, 16'h0000);
        cout("add_back_t0", 8'h00, 8'h00, 6'b000000);
        chk("add_r2", {16'd0, regs[2]}, 32'h0006);

        // SUB R3, R1 with run held high, then MV R5, R2 back-to-back
        tick(1'b1, 16'h3640);
        cout("sub_t0", 8'h00, 8'h00, 6'b000000);
        tick(1'b1, 16'h3640);
        cout("sub_t1", 8'h00, 8'h08, 6'b100000);
        tick(1'b1, 16'h3640);
        cout("sub_t2", 8'h00, 8'h02, 6'b010010);
        tick(1'b1, 16'h3640);
        cout("sub_t3", 8'h08, 8'h00, 6'b001001);
        tick(1'b1, 16'h0A80);
        cout("b2b_t0", 8'h00, 8'h00, 6'b000000);
        chk("sub_r3", {16'd0, regs[3]}, 32'h0000EEFF);
        tick(1'b0, 16'h0000);
        cout("b2b_mv_t1", 8'h20, 8'h04, 6'b000001);
        tick(1'b0, 16'h0000);
        cout("b2b_idle", 8'h00, 8'h00, 6'b000000);
        chk("b2b_r5", {16'd0, regs[5]}, 32'h0006);

        // NOP
        tick(1'b1, 16'hF000);
        cout("nop_t0", 8'h00, 8'h00, 6'b000000);
        tick(1'b0, 16'h0000);
        cout("nop_t1", 8'h00, 8'h00, 6'b000001);
        tick(1'b0, 16'h0000);
        cout("nop_back_t0", 8'h00, 8'h00, 6'b000000);

        // Reset in the middle of T2 of an ADD
        tick(1'b1, 16'h2480);
        tick(1'b0, 16'h0000);
        tick(1'b0, 16'h0000);
        cout("rst_pre_t2", 8'h00, 8'h04, 6'b010000);
        reset_n = 1'b0;
        #1;
        cout("rst_async_outs", 8'h00, 8'h00, 6'b000000);
        chk("rst_state", {30'd0, dut.state}, 32'd0);
        chk("rst_ir", {16'd0, dut.ir}, 32'd0);
        @(negedge clock);
        #1;
        cout("rst_held", 8'h00, 8'h00, 6'b000000);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 16'hFFFF);
            cout("rst_idle", 8'h00, 8'h00, 6'b000000);
        end
        chk("rst_r2_kept", {16'd0, regs[2]}, 32'h0006);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
